// File: rtl/ticket_vend_pkg.sv
// Shared types and constants for the multi-destination ticket vending controller.
package ticket_vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_CHANGE  = 2'd3
    } vend_state_e;

    localparam int unsigned DFLT_N_DEST   = 4;
    localparam int unsigned DFLT_CREDIT_W = 8;

    // Destination 0 sits in the low byte: {40, 25, 15, 10}
    localparam logic [DFLT_N_DEST*DFLT_CREDIT_W-1:0] DFLT_PRICE_TBL =
        {8'd40, 8'd25, 8'd15, 8'd10};

endpackage

// File: rtl/vend_timeout_ctr.sv
// Idle-cycle counter: counts enabled cycles, pulses expire_c_o on the enabled
// cycle where the count has reached TIMEOUT_CYC-1, then starts over.
module vend_timeout_ctr
    import ticket_vend_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_c_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_c_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_c_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ticket_vend_fsm.sv
// Ticket vending controller: collects coin credit, sells one ticket against a
// runtime price table, then pays out remaining credit as change.
module ticket_vend_fsm
    import ticket_vend_pkg::*;
#(
    parameter int unsigned N_DEST      = 4,
    parameter int unsigned CREDIT_W    = 8,
    parameter int unsigned MAX_CREDIT  = 200,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned SEL_W       = $clog2(N_DEST)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       coin_valid,
    input  logic [CREDIT_W-1:0]        coin_val,
    input  logic                       sel_valid,
    input  logic [SEL_W-1:0]           sel_dest,
    input  logic                       cancel,
    input  logic [N_DEST*CREDIT_W-1:0] price_tbl,
    output logic                       coin_reject,
    output logic                       sel_err,
    output logic                       ticket_valid,
    output logic [SEL_W-1:0]           ticket_dest,
    input  logic                       ticket_ready,
    output logic                       change_valid,
    output logic [CREDIT_W-1:0]        change_amt,
    input  logic                       change_ready,
    output logic [CREDIT_W-1:0]        credit,
    output logic                       busy
);

    localparam int unsigned SUM_W = CREDIT_W + 1;
    localparam int unsigned IDX_W = SEL_W + $clog2(CREDIT_W) + 1;

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
    logic [SEL_W-1:0]    ticket_dest_q, ticket_dest_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sel_err_q, sel_err_d;
    logic                ticket_valid_q, ticket_valid_d;
    logic                change_valid_q, change_valid_d;
    logic                busy_q, busy_d;

    logic                accepting;
    logic                in_collect;
    logic [SUM_W-1:0]    coin_sum;
    logic                coin_ok;
    logic [CREDIT_W-1:0] eff_credit;
    logic                sel_idx_ok;
    logic [IDX_W-1:0]    price_base;
    logic [CREDIT_W-1:0] price;
    logic                strobe;
    logic                tmo_expire;
    logic                cancel_now;
    logic                sel_bad;

    assign accepting  = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
    assign in_collect = (state_q == ST_COLLECT);

    // Coin acceptance uses one extra bit so an overflowing sum is caught, not wrapped
    assign coin_sum   = SUM_W'(credit_q) + SUM_W'(coin_val);
    assign coin_ok    = coin_valid && accepting && (coin_val != '0)
                        && (coin_sum <= SUM_W'(MAX_CREDIT));
    assign eff_credit = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;

    assign sel_idx_ok = (32'(sel_dest) < N_DEST);
    assign price_base = IDX_W'(sel_dest) * IDX_W'(CREDIT_W);
    assign price      = sel_idx_ok ? price_tbl[price_base +: CREDIT_W] : '0;

    assign strobe     = coin_valid || sel_valid || cancel;
    assign cancel_now = in_collect && (cancel || tmo_expire);
    assign sel_bad    = sel_valid && accepting && !cancel_now
                        && (!sel_idx_ok || (eff_credit < price));

    vend_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (!in_collect || strobe),
        .en_i       (in_collect && !strobe),
        .expire_c_o (tmo_expire)
    );

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            change_amt_q   <= '0;
            ticket_dest_q  <= '0;
            coin_reject_q  <= 1'b0;
            sel_err_q      <= 1'b0;
            ticket_valid_q <= 1'b0;
            change_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_amt_q   <= change_amt_d;
            ticket_dest_q  <= ticket_dest_d;
            coin_reject_q  <= coin_reject_d;
            sel_err_q      <= sel_err_d;
            ticket_valid_q <= ticket_valid_d;
            change_valid_q <= change_valid_d;
            busy_q         <= busy_d;
        end
    end

    // Next state and datapath updates
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        change_amt_d  = change_amt_q;
        ticket_dest_d = ticket_dest_q;
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                credit_d = eff_credit;
                if (cancel_now) begin
                    if (eff_credit != '0) begin
                        state_d      = ST_CHANGE;
                        change_amt_d = eff_credit;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (sel_valid && !sel_bad) begin
                    state_d       = ST_VEND;
                    ticket_dest_d = sel_dest;
                    credit_d      = eff_credit - price;
                end else if (coin_ok) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_VEND: begin
                if (ticket_ready) begin
                    if (credit_q != '0) begin
                        state_d      = ST_CHANGE;
                        change_amt_d = credit_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_CHANGE: begin
                if (change_ready) begin
                    state_d  = ST_IDLE;
                    credit_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered output values for the coming cycle
    always_comb begin
        coin_reject_d  = coin_valid && !coin_ok;
        sel_err_d      = sel_bad;
        ticket_valid_d = (state_d == ST_VEND);
        change_valid_d = (state_d == ST_CHANGE);
        busy_d         = (state_d == ST_VEND) || (state_d == ST_CHANGE);
    end

    assign coin_reject  = coin_reject_q;
    assign sel_err      = sel_err_q;
    assign ticket_valid = ticket_valid_q;
    assign ticket_dest  = ticket_dest_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign credit       = credit_q;
    assign busy         = busy_q;

endmodule
